// File: rtl/uart_msg_serialiser.sv
// Streams one MSG_BYTES-wide message LSB-first to a UART TX core over a valid/ready byte handshake.
// Optional UART_TX_CHECKSUM_EN appends an XOR-of-all-bytes checksum byte to every frame.
module uart_msg_serialiser #(
   parameter int MSG_BYTES = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   n_reset,
   input  logic [8*MSG_BYTES-1:0] uart_out_msg,
   input  logic                   uart_out_req,
   output logic                   uart_out_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic [CNT_WIDTH-1:0]   msg_count
);

   localparam int MSG_W = 8 * MSG_BYTES;
   localparam int IDX_W = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);

`ifdef UART_TX_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
`else
   typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

   state_t                 state_q, state_d;
   logic [MSG_W-1:0]       shiftReg_q, shiftReg_d;
   logic [MSG_W-1:0]       shifted;
   logic [IDX_W-1:0]       byteIdx_q, byteIdx_d;
   logic                   ready_q, ready_d;
   logic                   txValid_q, txValid_d;
   logic [7:0]             txData_q, txData_d;
   logic [CNT_WIDTH-1:0]   msgCount_q, msgCount_d;
`ifdef UART_TX_CHECKSUM_EN
   logic [7:0]             csum_q, csum_d;
`endif

   // State and all output registers; reset returns to idle and drops any partial frame
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q    <= IDLE;
         shiftReg_q <= '0;
         byteIdx_q  <= '0;
         ready_q    <= 1'b1;
         txValid_q  <= 1'b0;
         txData_q   <= '0;
         msgCount_q <= '0;
`ifdef UART_TX_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         shiftReg_q <= shiftReg_d;
         byteIdx_q  <= byteIdx_d;
         ready_q    <= ready_d;
         txValid_q  <= txValid_d;
         txData_q   <= txData_d;
         msgCount_q <= msgCount_d;
`ifdef UART_TX_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   // Next-state logic; the next byte is precomputed so outputs stay registered at 1 byte/cycle
   always_comb begin
      state_d    = state_q;
      shiftReg_d = shiftReg_q;
      byteIdx_d  = byteIdx_q;
      ready_d    = ready_q;
      txValid_d  = txValid_q;
      txData_d   = txData_q;
      msgCount_d = msgCount_q;
      shifted    = shiftReg_q >> 8;
`ifdef UART_TX_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (uart_out_req && ready_q) begin
               shiftReg_d = uart_out_msg;
               byteIdx_d  = '0;
               txData_d   = uart_out_msg[7:0];
               txValid_d  = 1'b1;
               ready_d    = 1'b0;
               state_d    = SEND;
`ifdef UART_TX_CHECKSUM_EN
               csum_d     = '0;
`endif
            end
         end
         SEND: begin
            if (tx_ready) begin
`ifdef UART_TX_CHECKSUM_EN
               csum_d = csum_q ^ txData_q;
`endif
               if (byteIdx_q == LAST_IDX) begin
`ifdef UART_TX_CHECKSUM_EN
                  txData_d = csum_q ^ txData_q;
                  state_d  = CSUM;
`else
                  txValid_d  = 1'b0;
                  ready_d    = 1'b1;
                  msgCount_d = msgCount_q + 1'b1;
                  state_d    = IDLE;
`endif
               end else begin
                  shiftReg_d = shifted;
                  txData_d   = shifted[7:0];
                  byteIdx_d  = byteIdx_q + 1'b1;
               end
            end
         end
`ifdef UART_TX_CHECKSUM_EN
         CSUM: begin
            if (tx_ready) begin
               txValid_d  = 1'b0;
               ready_d    = 1'b1;
               msgCount_d = msgCount_q + 1'b1;
               state_d    = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   assign uart_out_ready = ready_q;
   assign tx_valid       = txValid_q;
   assign tx_data        = txData_q;
   assign msg_count      = msgCount_q;

endmodule

// File: tb/tb_uart_msg_serialiser.sv
// Self-checking bench for uart_msg_serialiser: directed scenarios plus a randomized run
// scored against a byte-queue model; a second 1-byte, 2-bit-counter instance covers wrap.
module tb_uart_msg_serialiser;

   localparam int MB = 4;
`ifdef UART_TX_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif
   localparam int FL = MB + CS;

   logic        clk = 1'b0;
   logic        n_reset;
   logic [31:0] msg;
   logic        req;
   logic        ready;
   logic [7:0]  txData;
   logic        txValid;
   logic        txReady;
   logic [15:0] msgCount;

   logic [7:0]  msg2;
   logic        req2;
   logic        ready2;
   logic [7:0]  txData2;
   logic        txValid2;
   logic        txReady2;
   logic [1:0]  msgCount2;

   int errors = 0;
   int checks = 0;
   int expCount = 0;

   logic [7:0] capQ[$];
   logic [7:0] expQ[$];
   bit         monEn = 1'b0;

   always #5 clk = ~clk;

   uart_msg_serialiser #(.MSG_BYTES(MB), .CNT_WIDTH(16)) dut (
      .clk(clk), .n_reset(n_reset), .uart_out_msg(msg), .uart_out_req(req),
      .uart_out_ready(ready), .tx_data(txData), .tx_valid(txValid),
      .tx_ready(txReady), .msg_count(msgCount)
   );

   uart_msg_serialiser #(.MSG_BYTES(1), .CNT_WIDTH(2)) dut2 (
      .clk(clk), .n_reset(n_reset), .uart_out_msg(msg2), .uart_out_req(req2),
      .uart_out_ready(ready2), .tx_data(txData2), .tx_valid(txValid2),
      .tx_ready(txReady2), .msg_count(msgCount2)
   );

   // Records every byte the TX core would accept at the coming rising edge
   always @(negedge clk) begin
      if (monEn && n_reset && txValid && txReady)
         capQ.push_back(txData);
   end

   // Frame byte i of message m: message bytes LSB-first, then optional XOR checksum
   function automatic logic [7:0] expByte(input logic [31:0] m, input int i);
      logic [7:0] x;
      if (i < MB) return 8'((m >> (8 * i)) & 32'hFF);
      x = 8'h00;
      for (int k = 0; k < MB; k++) x = x ^ 8'((m >> (8 * k)) & 32'hFF);
      return x;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkFrameByte(input string name, input logic [31:0] m, input int i);
      checks++;
      if (txValid !== 1'b1 || txData !== expByte(m, i) || ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s byte%0d: valid=%b data=%h ready=%b, required valid=1 data=%h ready=0",
                  name, i, txValid, txData, ready, expByte(m, i));
      end
   endtask

   task automatic test_reset();
      n_reset  = 1'b0;
      req      = 1'b0;
      msg      = '0;
      txReady  = 1'b0;
      req2     = 1'b0;
      msg2     = '0;
      txReady2 = 1'b0;
      step();
      step();
      n_reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (ready !== 1'b1 || txValid !== 1'b0 || msgCount !== 16'd0 || txData !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset cycle%0d: ready=%b valid=%b count=%0d data=%h, required 1 0 0 00",
                     c, ready, txValid, msgCount, txData);
         end
         step();
      end
   endtask

   task automatic test_single();
      txReady = 1'b1;
      msg     = 32'h11223344;
      req     = 1'b1;
      step();
      req = 1'b0;
      msg = $urandom;
      for (int i = 0; i < FL; i++) begin
         checkFrameByte("single", 32'h11223344, i);
         step();
      end
      expCount++;
      checks++;
      if (txValid !== 1'b0 || ready !== 1'b1 || msgCount !== 16'(expCount)) begin
         errors++;
         $display("[TB] FAIL single_end: valid=%b ready=%b count=%0d, required 0 1 %0d",
                  txValid, ready, msgCount, expCount);
      end
   endtask

   task automatic test_stall();
      txReady = 1'b0;
      msg     = 32'h11223344;
      req     = 1'b1;
      step();
      msg = 32'hDEADBEEF;
      for (int i = 0; i < FL; i++) begin
         for (int s = 0; s < 3; s++) begin
            txReady = 1'b0;
            checkFrameByte("stall", 32'h11223344, i);
            step();
         end
         txReady = 1'b1;
         if (i == FL - 1) req = 1'b0;
         checkFrameByte("stall_hs", 32'h11223344, i);
         step();
      end
      expCount++;
      checks++;
      if (txValid !== 1'b0 || ready !== 1'b1 || msgCount !== 16'(expCount)) begin
         errors++;
         $display("[TB] FAIL stall_end: valid=%b ready=%b count=%0d, required 0 1 %0d",
                  txValid, ready, msgCount, expCount);
      end
      step();
      checks++;
      if (txValid !== 1'b0 || ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stall_ignored_req: valid=%b ready=%b, required 0 1", txValid, ready);
      end
   endtask

   task automatic test_back_to_back();
      txReady = 1'b1;
      msg     = 32'h11223344;
      req     = 1'b1;
      step();
      req = 1'b0;
      for (int i = 0; i < FL; i++) begin
         checkFrameByte("b2b_first", 32'h11223344, i);
         step();
      end
      checks++;
      if (txValid !== 1'b0 || ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_gap: valid=%b ready=%b, required 0 1", txValid, ready);
      end
      msg = 32'hDEADBEEF;
      req = 1'b1;
      step();
      req = 1'b0;
      for (int i = 0; i < FL; i++) begin
         checkFrameByte("b2b_second", 32'hDEADBEEF, i);
         step();
      end
      expCount += 2;
      checks++;
      if (txValid !== 1'b0 || ready !== 1'b1 || msgCount !== 16'(expCount)) begin
         errors++;
         $display("[TB] FAIL b2b_end: valid=%b ready=%b count=%0d, required 0 1 %0d",
                  txValid, ready, msgCount, expCount);
      end
   endtask

   task automatic test_reset_mid();
      txReady = 1'b1;
      msg     = 32'h11223344;
      req     = 1'b1;
      step();
      req = 1'b0;
      checkFrameByte("rstmid", 32'h11223344, 0);
      step();
      checkFrameByte("rstmid", 32'h11223344, 1);
      step();
      n_reset = 1'b0;
      #1;
      expCount = 0;
      checks++;
      if (txValid !== 1'b0 || ready !== 1'b1 || txData !== 8'h00 || msgCount !== 16'd0) begin
         errors++;
         $display("[TB] FAIL rstmid_async: valid=%b ready=%b data=%h count=%0d, required 0 1 00 0",
                  txValid, ready, txData, msgCount);
      end
      step();
      n_reset = 1'b1;
      step();
      msg = 32'h00000001;
      req = 1'b1;
      step();
      req = 1'b0;
      for (int i = 0; i < FL; i++) begin
         checkFrameByte("after_rst", 32'h00000001, i);
         step();
      end
      expCount++;
      checks++;
      if (msgCount !== 16'(expCount) || ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL after_rst_end: count=%0d ready=%b, required %0d 1", msgCount, ready, expCount);
      end
   endtask

   task automatic test_random();
      int nMsgs = 0;
      int base;
      bit done = 1'b0;
      bit modelIdle;
      logic [31:0] m;
      capQ.delete();
      expQ.delete();
      base  = expCount;
      monEn = 1'b1;
      for (int c = 0; c < 4000 && !done; c++) begin
         modelIdle = (capQ.size() == expQ.size());
         checks++;
         if (ready !== modelIdle || msgCount !== 16'(base + nMsgs - (modelIdle ? 0 : 1))) begin
            errors++;
            $display("[TB] FAIL random_cycle%0d: ready=%b count=%0d, required %b %0d",
                     c, ready, msgCount, modelIdle, base + nMsgs - (modelIdle ? 0 : 1));
         end
         if (modelIdle && nMsgs == 20) begin
            done = 1'b1;
         end else if (modelIdle && ($urandom_range(0, 2) != 0)) begin
            m   = $urandom;
            msg = m;
            req = 1'b1;
            for (int i = 0; i < FL; i++) expQ.push_back(expByte(m, i));
            nMsgs++;
         end else if (!modelIdle) begin
            req = 1'($urandom_range(0, 1));
            msg = $urandom;
         end else begin
            req = 1'b0;
         end
         txReady = ($urandom_range(0, 3) != 0);
         if (!done) step();
      end
      req   = 1'b0;
      monEn = 1'b0;
      expCount = base + nMsgs;
      checks++;
      if (!done || capQ.size() != expQ.size()) begin
         errors++;
         $display("[TB] FAIL random_drain: done=%b captured=%0d bytes, required %0d bytes",
                  done, capQ.size(), expQ.size());
      end
      for (int i = 0; i < expQ.size() && i < capQ.size(); i++) begin
         checks++;
         if (capQ[i] !== expQ[i]) begin
            errors++;
            $display("[TB] FAIL random_byte%0d: got %h, required %h", i, capQ[i], expQ[i]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] b;
      txReady2 = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         b = 8'($urandom);
         checks++;
         if (ready2 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_ready msg%0d: ready=%b, required 1", k, ready2);
         end
         msg2 = b;
         req2 = 1'b1;
         step();
         req2 = 1'b0;
         for (int i = 0; i < 1 + CS; i++) begin
            checks++;
            if (txValid2 !== 1'b1 || txData2 !== b || ready2 !== 1'b0) begin
               errors++;
               $display("[TB] FAIL wrap_byte msg%0d: valid=%b data=%h ready=%b, required 1 %h 0",
                        k, txValid2, txData2, ready2, b);
            end
            step();
         end
         checks++;
         if (msgCount2 !== 2'(k % 4) || txValid2 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_count msg%0d: count=%0d valid=%b, required %0d 0",
                     k, msgCount2, txValid2, k % 4);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

endmodule
